l2_arbiter: RTL
===============

L2_ARBITER -- requirements
Module: l2_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning address/data width in bits.
REQ-002 SHALL have parameter MAX_HOLD, default 8, meaning max fulfilled beats one port keeps the grant while the other port waits.
REQ-003 SHALL have ports:
- clk  input  1  sole clock.
- reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have, per requester port n in {0 = icache, 1 = dcache}:
- reqn_address  input  XLEN  L2 request address.
- reqn_type  input  memory_operation_e  load/store/flush op.
- reqn_valid  input  1  request pending.
- reqn_word_to_store  input  XLEN  store data.
- reqn_fetched_word  output  XLEN  L2 load data.
- reqn_fulfilled  output  1  request completed.
REQ-005 SHALL have downstream ports:
- l2_req_address  output  XLEN
- l2_req_type  output  memory_operation_e
- l2_req_valid  output  1
- l2_word_to_store  output  XLEN
- l2_fetched_word  input  XLEN
- l2_req_fulfilled  input  1
REQ-006 SHALL have grant  output  2  one-hot current owner, 2'b00 when idle.

Function
REQ-007 SHALL implement FSM states IDLE, GRANT0, GRANT1, held in a registered state variable.
REQ-008 SHALL keep a 1-bit registered priority pointer rr; rr=0 favours port 0 and rr=1 favours port 1.
REQ-009 IDLE with one valid SHALL go next cycle to that port's GRANT state; grant is registered, so there is one cycle of arbitration latency.
REQ-010 IDLE with both valid SHALL go to GRANTrr.
REQ-011 IDLE with none valid SHALL stay IDLE.
REQ-012 In GRANTn, l2_req_address, l2_req_type, l2_word_to_store and l2_req_valid SHALL combinationally equal port n's inputs.
REQ-013 In IDLE, l2_req_valid SHALL be 0 and the other l2 outputs SHALL be 0.
REQ-014 In GRANTn, reqn_fulfilled SHALL equal l2_req_fulfilled and reqn_fetched_word SHALL equal l2_fetched_word.
REQ-015 The non-granted port SHALL see fulfilled=0 and fetched_word=0.
REQ-016 SHALL keep a beat counter, width $clog2(MAX_HOLD)+1, cleared on entry to any GRANT state and incremented on each cycle where l2_req_fulfilled=1 in a GRANT state.
REQ-017 GRANTn with reqn_valid=0 SHALL go to IDLE next cycle and set rr to the other port.
REQ-018 GRANTn with l2_req_fulfilled=1, the other port valid, and the incremented beat count equal to MAX_HOLD SHALL force a release: next state IDLE, rr set to the other port.
REQ-019 In all other GRANTn cases the grant SHALL be retained, so a multi-word line fill or writeback is not interleaved.
REQ-020 The other port's valid going high mid-grant SHALL NOT change the current grant except via REQ-018.
REQ-021 l2_req_fulfilled=1 while IDLE SHALL be ignored: no port fulfilled, no state change.
REQ-022 A requester dropping valid in the same cycle as fulfilled SHALL still receive that fulfilled pulse, then release per REQ-017 on the following cycle.
REQ-023 Any non-one-hot grant value other than 2'b00 is illegal and SHALL never occur.

Reset
REQ-024 reset=1 at a clk edge SHALL force state=IDLE, rr=0, beat counter=0 and grant=2'b00.
REQ-025 During and immediately after reset, l2_req_valid, req0_fulfilled and req1_fulfilled SHALL be 0.
REQ-026 Reset asserted mid-grant SHALL abandon the in-flight request with no fulfilled pulse forwarded in the reset cycle; the requester re-arbitrates after reset.

Verification
REQ-027 Only port 1 valid (load, address 0x0000_0040) -> grant=2'b10 one cycle later, l2_req_address=0x40; l2 fulfilled with 0xDEADBEEF -> req1_fetched_word=0xDEADBEEF and req1_fulfilled=1; req0_fulfilled stays 0.
REQ-028 Both ports valid in the same cycle after reset -> port 0 granted; after port 0 drops valid, port 1 is granted exactly two cycles later (IDLE, then GRANT1).
REQ-029 Port 1 holds valid for 12 beats with port 0 waiting, MAX_HOLD=8 -> grant moves to port 0 after the 8th fulfilled beat and returns to port 1 once port 0 releases.
REQ-030 Port 0 alone holds valid for 12 beats, port 1 idle -> no forced release; grant stays 2'b01 for all 12 beats.
REQ-031 Reset pulsed while in GRANT1 with l2_req_fulfilled=1 -> grant=2'b00 and req1_fulfilled=0 that cycle; next both-valid arbitration grants port 0.
REQ-032 l2_req_fulfilled pulsed while IDLE -> both reqn_fulfilled stay 0 and state stays IDLE.

Source files
------------

// File: rtl/l2_arbiter.sv
// l2_arbiter: two-port (icache/dcache) arbiter in front of a shared L2.
// A registered FSM owns the grant; the downstream request path and the
// upstream response path are steered combinationally by the current owner.
// Ownership is kept across beats so multi-word fills/writebacks are not
// interleaved, but is forcibly released after MAX_HOLD fulfilled beats
// when the other port is waiting.

package l2_arbiter_pkg;
    typedef enum logic [1:0] {
        MEM_LOAD  = 2'd0,
        MEM_STORE = 2'd1,
        MEM_FLUSH = 2'd2
    } memory_operation_e;
endpackage

module l2_arbiter
    import l2_arbiter_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int MAX_HOLD = 8
) (
    input  logic              clk,
    input  logic              reset,

    input  logic [XLEN-1:0]   req0_address,
    input  memory_operation_e req0_type,
    input  logic              req0_valid,
    input  logic [XLEN-1:0]   req0_word_to_store,
    output logic [XLEN-1:0]   req0_fetched_word,
    output logic              req0_fulfilled,

    input  logic [XLEN-1:0]   req1_address,
    input  memory_operation_e req1_type,
    input  logic              req1_valid,
    input  logic [XLEN-1:0]   req1_word_to_store,
    output logic [XLEN-1:0]   req1_fetched_word,
    output logic              req1_fulfilled,

    output logic [XLEN-1:0]   l2_req_address,
    output memory_operation_e l2_req_type,
    output logic              l2_req_valid,
    output logic [XLEN-1:0]   l2_word_to_store,
    input  logic [XLEN-1:0]   l2_fetched_word,
    input  logic              l2_req_fulfilled,

    output logic [1:0]        grant
);

    localparam int BEAT_W = $clog2(MAX_HOLD) + 1;
    localparam logic [BEAT_W-1:0] HOLD_LIMIT = BEAT_W'(MAX_HOLD);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                rr_q, rr_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [BEAT_W-1:0]   beat_inc;

    logic [1:0]          fulfilled_vec;
    logic [XLEN-1:0]     fetched_vec [2];

    // State, priority pointer and beat counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            beat_q  <= beat_d;
        end
    end

    // Next-state: arbitrate from IDLE, hold ownership, release on drop or hold limit.
    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        beat_d   = beat_q;
        beat_inc = beat_q + 1'b1;
        case (state_q)
            IDLE: begin
                // Counter is zero on entry to any grant state.
                beat_d = '0;
                if (req0_valid && req1_valid) begin
                    state_d = rr_q ? GRANT1 : GRANT0;
                end else if (req0_valid) begin
                    state_d = GRANT0;
                end else if (req1_valid) begin
                    state_d = GRANT1;
                end
            end
            GRANT0: begin
                if (!req0_valid) begin
                    state_d = IDLE;
                    rr_d    = 1'b1;
                end else if (l2_req_fulfilled) begin
                    beat_d = beat_inc;
                    if (req1_valid && (beat_inc == HOLD_LIMIT)) begin
                        state_d = IDLE;
                        rr_d    = 1'b1;
                    end
                end
            end
            GRANT1: begin
                if (!req1_valid) begin
                    state_d = IDLE;
                    rr_d    = 1'b0;
                end else if (l2_req_fulfilled) begin
                    beat_d = beat_inc;
                    if (req0_valid && (beat_inc == HOLD_LIMIT)) begin
                        state_d = IDLE;
                        rr_d    = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Owner decode; masked while reset is high so an in-flight request is
    // abandoned without forwarding a fulfilled pulse in the reset cycle.
    always_comb begin
        grant = 2'b00;
        if (!reset) begin
            grant[0] = (state_q == GRANT0);
            grant[1] = (state_q == GRANT1);
        end
    end

    // Downstream request mux: owner's inputs pass through, zeros when idle.
    always_comb begin
        l2_req_address   = '0;
        l2_req_type      = MEM_LOAD;
        l2_req_valid     = 1'b0;
        l2_word_to_store = '0;
        if (grant[0]) begin
            l2_req_address   = req0_address;
            l2_req_type      = req0_type;
            l2_req_valid     = req0_valid;
            l2_word_to_store = req0_word_to_store;
        end else if (grant[1]) begin
            l2_req_address   = req1_address;
            l2_req_type      = req1_type;
            l2_req_valid     = req1_valid;
            l2_word_to_store = req1_word_to_store;
        end
    end

    // Upstream response steering: only the owner sees the L2 response.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_resp
            assign fulfilled_vec[gi] = grant[gi] & l2_req_fulfilled;
            assign fetched_vec[gi]   = grant[gi] ? l2_fetched_word : '0;
        end
    endgenerate

    assign req0_fulfilled    = fulfilled_vec[0];
    assign req1_fulfilled    = fulfilled_vec[1];
    assign req0_fetched_word = fetched_vec[0];
    assign req1_fetched_word = fetched_vec[1];

endmodule
